// File: rtl/conv_pkg.sv
// Shared types and helpers for the sliding tap window.
package conv_pkg;

  typedef enum logic [1:0] {
    EMPTY,
    FILLING,
    FULL
  } conv_win_state_t;

  // Counter width able to hold values 0..n-1, never less than one bit.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/conv_tap_stage.sv
// One window tap: a DATA_WIDTH register with load enable and synchronous clear.
module conv_tap_stage #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  clr,
  input  logic                  en,
  input  logic [DATA_WIDTH-1:0] d,
  output logic [DATA_WIDTH-1:0] q
);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/conv_tap_window.sv
// Sliding window of TAPS samples with valid/ready on both sides.
// Optional decimation of emitted windows via macro CONV_TAP_STRIDE_EN.
module conv_tap_window
  import conv_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int TAPS       = 3,
  parameter int STRIDE     = 1
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         clrh,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [DATA_WIDTH-1:0]        d_in,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [TAPS*DATA_WIDTH-1:0]   taps,
  output logic [$clog2(TAPS+1)-1:0]    fill_cnt
);

  localparam int FW = cnt_width(TAPS + 1);
  localparam logic [FW-1:0] LAST_FILL = FW'(TAPS - 1);

  conv_win_state_t       state_reg;
  logic [FW-1:0]         fill_cnt_reg;
  logic                  out_valid_reg;
  logic                  accept;
  logic                  becomes_full;
  logic                  stride_wrap;
  logic                  emit;
  logic [DATA_WIDTH-1:0] tap_q [TAPS];

  assign in_ready     = !out_valid_reg || out_ready;
  assign accept       = in_valid && in_ready;
  assign becomes_full = (state_reg == FILLING) && (fill_cnt_reg == LAST_FILL);
  assign emit         = becomes_full || ((state_reg == FULL) && stride_wrap);

`ifdef CONV_TAP_STRIDE_EN
  localparam int SW = cnt_width(STRIDE);
  localparam logic [SW-1:0] STRIDE_LAST = SW'(STRIDE - 1);

  logic [SW-1:0] stride_cnt_reg;

  // A window goes out on the accept that returns the counter to zero.
  assign stride_wrap = (stride_cnt_reg == STRIDE_LAST);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stride_cnt_reg <= '0;
    end else if (clrh) begin
      stride_cnt_reg <= '0;
    end else if (accept && (state_reg == FULL)) begin
      stride_cnt_reg <= stride_wrap ? '0 : stride_cnt_reg + SW'(1);
    end
  end
`else
  logic unused_stride;
  assign unused_stride = ^STRIDE;
  assign stride_wrap   = 1'b1;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg     <= EMPTY;
      fill_cnt_reg  <= '0;
      out_valid_reg <= 1'b0;
    end else if (clrh) begin
      state_reg     <= EMPTY;
      fill_cnt_reg  <= '0;
      out_valid_reg <= 1'b0;
    end else begin
      if (accept) begin
        case (state_reg)
          EMPTY: begin
            state_reg    <= FILLING;
            fill_cnt_reg <= FW'(1);
          end
          FILLING: begin
            fill_cnt_reg <= fill_cnt_reg + FW'(1);
            if (becomes_full) begin
              state_reg <= FULL;
            end
          end
          default: ;  // saturated: the window just slides
        endcase
      end
      if (accept && emit) begin
        out_valid_reg <= 1'b1;
      end else if (out_ready) begin
        out_valid_reg <= 1'b0;
      end
    end
  end

  for (genvar gi = 0; gi < TAPS; gi++) begin : g_tap
    logic [DATA_WIDTH-1:0] stage_d;
    if (gi == 0) begin : g_head
      assign stage_d = d_in;
    end else begin : g_chain
      assign stage_d = tap_q[gi-1];
    end
    conv_tap_stage #(
      .DATA_WIDTH(DATA_WIDTH)
    ) u_stage (
      .clk  (clk),
      .rstn (rstn),
      .clr  (clrh),
      .en   (accept),
      .d    (stage_d),
      .q    (tap_q[gi])
    );
    assign taps[gi*DATA_WIDTH +: DATA_WIDTH] = tap_q[gi];
  end

  assign out_valid = out_valid_reg;
  assign fill_cnt  = fill_cnt_reg;

endmodule

// File: tb/tb_conv_tap_window.sv
// Directed bench for conv_tap_window: vector table plus reset and stride sequences.
module tb_conv_tap_window;

  logic        clk = 1'b0;
  logic        rstn;
  logic        clrh;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  d_in;
  logic        out_valid;
  logic        out_ready;
  logic [23:0] taps;
  logic [1:0]  fill_cnt;

  logic        iv_s;
  logic        ir_s;
  logic [7:0]  d_s;
  logic        ov_s;
  logic        ordy_s;
  logic [23:0] taps_s;
  logic [1:0]  fill_s;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  conv_tap_window #(.DATA_WIDTH(8), .TAPS(3), .STRIDE(1)) dut (
    .clk(clk), .rstn(rstn), .clrh(clrh), .in_valid(in_valid), .in_ready(in_ready),
    .d_in(d_in), .out_valid(out_valid), .out_ready(out_ready), .taps(taps), .fill_cnt(fill_cnt)
  );

  conv_tap_window #(.DATA_WIDTH(8), .TAPS(3), .STRIDE(2)) dut_s (
    .clk(clk), .rstn(rstn), .clrh(1'b0), .in_valid(iv_s), .in_ready(ir_s),
    .d_in(d_s), .out_valid(ov_s), .out_ready(ordy_s), .taps(taps_s), .fill_cnt(fill_s)
  );

  typedef struct {
    logic        clrh;
    logic        iv;
    logic [7:0]  d;
    logic        ordy;
    logic        ir;
    logic        ov;
    logic [23:0] tp;
    logic [1:0]  fc;
  } vec_t;

  vec_t vecs [18];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Drive one cycle's inputs, check in_ready before the edge, outputs after it.
  task automatic apply(input vec_t v, input string name);
    clrh      = v.clrh;
    in_valid  = v.iv;
    d_in      = v.d;
    out_ready = v.ordy;
    #1;
    chk({name, " in_ready"}, {31'd0, in_ready}, {31'd0, v.ir});
    @(posedge clk);
    #1;
    chk({name, " out_valid"}, {31'd0, out_valid}, {31'd0, v.ov});
    chk({name, " taps"}, {8'd0, taps}, {8'd0, v.tp});
    chk({name, " fill_cnt"}, {30'd0, fill_cnt}, {30'd0, v.fc});
    $display("[TB] %s: d_in=%h taps=%h fill=%0d out_valid=%b", name, v.d, taps, fill_cnt, out_valid);
  endtask

  initial begin
    vec_t v;
    logic [23:0] exp_tp;
    logic        exp_ov;

    //             clrh  iv    d      ordy  ir    ov    taps        fill
    vecs[0]  = '{1'b0, 1'b1, 8'h11, 1'b1, 1'b1, 1'b0, 24'h000011, 2'd1};
    vecs[1]  = '{1'b0, 1'b1, 8'h22, 1'b1, 1'b1, 1'b0, 24'h001122, 2'd2};
    vecs[2]  = '{1'b0, 1'b1, 8'h33, 1'b1, 1'b1, 1'b1, 24'h112233, 2'd3};
    vecs[3]  = '{1'b0, 1'b1, 8'h44, 1'b0, 1'b0, 1'b1, 24'h112233, 2'd3};
    vecs[4]  = '{1'b0, 1'b1, 8'h44, 1'b0, 1'b0, 1'b1, 24'h112233, 2'd3};
    vecs[5]  = '{1'b0, 1'b1, 8'h44, 1'b1, 1'b1, 1'b1, 24'h223344, 2'd3};
    vecs[6]  = '{1'b1, 1'b1, 8'h55, 1'b1, 1'b1, 1'b0, 24'h000000, 2'd0};
    vecs[7]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 24'h000000, 2'd0};
    vecs[8]  = '{1'b0, 1'b1, 8'hA1, 1'b1, 1'b1, 1'b0, 24'h0000A1, 2'd1};
    vecs[9]  = '{1'b0, 1'b1, 8'hA2, 1'b1, 1'b1, 1'b0, 24'h00A1A2, 2'd2};
    vecs[10] = '{1'b0, 1'b1, 8'hA3, 1'b1, 1'b1, 1'b1, 24'hA1A2A3, 2'd3};
    vecs[11] = '{1'b0, 1'b1, 8'hA4, 1'b1, 1'b1, 1'b1, 24'hA2A3A4, 2'd3};
    vecs[12] = '{1'b0, 1'b1, 8'hA5, 1'b1, 1'b1, 1'b1, 24'hA3A4A5, 2'd3};
    vecs[13] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 24'hA3A4A5, 2'd3};
    vecs[14] = '{1'b0, 1'b1, 8'hB6, 1'b0, 1'b1, 1'b1, 24'hA4A5B6, 2'd3};
    vecs[15] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 24'hA4A5B6, 2'd3};
    vecs[16] = '{1'b0, 1'b1, 8'hC7, 1'b0, 1'b0, 1'b1, 24'hA4A5B6, 2'd3};
    vecs[17] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 24'hA4A5B6, 2'd3};

    rstn = 1'b0; clrh = 1'b0; in_valid = 1'b0; d_in = '0; out_ready = 1'b0;
    iv_s = 1'b0; d_s = '0; ordy_s = 1'b0;

    #12;
    chk("reset out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset taps", {8'd0, taps}, 32'd0);
    chk("reset fill_cnt", {30'd0, fill_cnt}, 32'd0);
    chk("reset in_ready", {31'd0, in_ready}, 32'd1);
    rstn = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 18; i++) begin
      apply(vecs[i], $sformatf("vec%0d", i));
    end

    // Asynchronous reset part-way through a fill.
    v = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 24'h000000, 2'd0};
    apply(v, "pre-clear");
    v = '{1'b0, 1'b1, 8'hE1, 1'b1, 1'b1, 1'b0, 24'h0000E1, 2'd1};
    apply(v, "rst fill1");
    v = '{1'b0, 1'b1, 8'hE2, 1'b1, 1'b1, 1'b0, 24'h00E1E2, 2'd2};
    apply(v, "rst fill2");
    in_valid = 1'b0;
    #2;
    rstn = 1'b0;
    #1;
    chk("async taps", {8'd0, taps}, 32'd0);
    chk("async fill_cnt", {30'd0, fill_cnt}, 32'd0);
    chk("async out_valid", {31'd0, out_valid}, 32'd0);
    chk("async in_ready", {31'd0, in_ready}, 32'd1);
    $display("[TB] async reset: taps=%h fill=%0d out_valid=%b", taps, fill_cnt, out_valid);
    #1;
    rstn = 1'b1;
    @(posedge clk);
    #1;
    v = '{1'b0, 1'b1, 8'hE3, 1'b1, 1'b1, 1'b0, 24'h0000E3, 2'd1};
    apply(v, "post-rst 1");
    v = '{1'b0, 1'b1, 8'hE4, 1'b1, 1'b1, 1'b0, 24'h00E3E4, 2'd2};
    apply(v, "post-rst 2");
    v = '{1'b0, 1'b1, 8'hE5, 1'b1, 1'b1, 1'b1, 24'hE3E4E5, 2'd3};
    apply(v, "post-rst 3");
    in_valid = 1'b0;

    // Stride instance (STRIDE=2): stream 0x01..0x07.
    for (int k = 1; k <= 7; k++) begin
      iv_s   = 1'b1;
      d_s    = 8'(k);
      ordy_s = 1'b1;
      #1;
      chk($sformatf("stride %0d in_ready", k), {31'd0, ir_s}, 32'd1);
      @(posedge clk);
      #1;
      exp_tp = {(k >= 3) ? 8'(k - 2) : 8'h00, (k >= 2) ? 8'(k - 1) : 8'h00, 8'(k)};
`ifdef CONV_TAP_STRIDE_EN
      exp_ov = (k >= 3) && (((k - 3) % 2) == 0);
`else
      exp_ov = (k >= 3);
`endif
      chk($sformatf("stride %0d out_valid", k), {31'd0, ov_s}, {31'd0, exp_ov});
      chk($sformatf("stride %0d taps", k), {8'd0, taps_s}, {8'd0, exp_tp});
      chk($sformatf("stride %0d fill_cnt", k), {30'd0, fill_s}, (k >= 3) ? 32'd3 : 32'(k));
      $display("[TB] stride d_in=%h taps=%h out_valid=%b", d_s, taps_s, ov_s);
    end
    iv_s = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
